cpu_state_sequencer: RTL

//   Multicycle CPU state register: emits state_o (codes::state_t) to the control decoder.

---
 rtl/cpu_state_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/cpu_state_sequencer.sv
// Multicycle CPU state register: FETCH -> EXEC1 -> EXEC2 with bus/mult-div holds, HALT and watchdog.
// Optional perf counters (cycle_count_o, instr_count_o) are built when SVM_PERF_COUNTERS_EN is defined.

package codes;
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC1 = 2'd1,
        EXEC2 = 2'd2,
        HALT  = 2'd3
    } state_t;
endpackage

module cpu_state_sequencer #(
    parameter int unsigned STALL_LIMIT = 255,
    parameter int unsigned STALL_W     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_waitrequest_i,
    input  logic          muldiv_busy_i,
    input  logic          halt_pc_i,
    output codes::state_t state_o,
    output logic          active_o,
    output logic          commit_o,
    output logic          stalled_o,
    output logic          timeout_o
`ifdef SVM_PERF_COUNTERS_EN
    ,
    output logic [31:0]   cycle_count_o,
    output logic [31:0]   instr_count_o
`endif
);
    import codes::*;

    localparam logic [STALL_W-1:0] LIMIT = STALL_W'(STALL_LIMIT);
    localparam logic [STALL_W-1:0] SAT   = {STALL_W{1'b1}};

    state_t               r_state;
    logic                 r_active;
    logic                 r_timeout;
    logic [STALL_W-1:0]   r_stall_cnt;

    state_t               w_next_norm;
    state_t               w_next;
    logic                 w_hold;
    logic                 w_fire;
    logic                 w_stalled;
    logic                 w_commit;
    logic [STALL_W-1:0]   w_stall_cnt_next;

    always_comb begin
        w_next_norm = r_state;
        case (r_state)
            FETCH:   if (!mem_waitrequest_i) w_next_norm = EXEC1;
            EXEC1:   if (!mem_waitrequest_i) w_next_norm = EXEC2;
            EXEC2: begin
                if (!(mem_waitrequest_i || muldiv_busy_i)) begin
                    w_next_norm = halt_pc_i ? HALT : FETCH;
                end
            end
            default: w_next_norm = HALT;
        endcase
    end

    // A stall that clears on the limit cycle takes the normal transition, not the timeout.
    assign w_hold    = (r_state != HALT) && (w_next_norm == r_state);
    assign w_fire    = w_hold && (r_stall_cnt == LIMIT);
    assign w_next    = w_fire ? HALT : w_next_norm;
    assign w_stalled = !reset && (r_state != HALT) && (w_next == r_state);
    assign w_commit  = (r_state == EXEC2) && !mem_waitrequest_i && !muldiv_busy_i && !reset;

    always_comb begin
        w_stall_cnt_next = '0;
        if (w_stalled) begin
            w_stall_cnt_next = (r_stall_cnt == SAT) ? r_stall_cnt : r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FETCH;
            r_active    <= 1'b1;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_next;
            r_active    <= (w_next != HALT);
            r_stall_cnt <= w_stall_cnt_next;
            if (w_fire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign state_o   = r_state;
    assign active_o  = r_active;
    assign commit_o  = w_commit;
    assign stalled_o = w_stalled;
    assign timeout_o = r_timeout;

`ifdef SVM_PERF_COUNTERS_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (r_active) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (w_commit) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
        end
    end

    assign cycle_count_o = r_cycle_cnt;
    assign instr_count_o = r_instr_cnt;
`endif

endmodule
